// File: rtl/reliability_to_network_bridge_arbiter_if.sv
// AXI-Stream bundle shared by the reliability sources and the network bridge port.
// The master drives the payload and tvalid; the slave drives tready.
interface reliability_to_network_bridge_arbiter_if #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned KeepWidth = 8,
  parameter int unsigned DestWidth = 16,
  parameter int unsigned UserWidth = 16
) ();

  logic                 tvalid;
  logic                 tready;
  logic [DataWidth-1:0] tdata;
  logic [KeepWidth-1:0] tkeep;
  logic [DestWidth-1:0] tid;
  logic [DestWidth-1:0] tdest;
  logic [UserWidth-1:0] tuser;
  logic                 tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    output tready
  );

endinterface

// File: rtl/reliability_to_network_bridge_arbiter.sv
// Packet-granular round-robin merge of the outbound and inbound reliability streams
// onto the single network bridge AXIS port, with a registered output and packet counters.
module reliability_to_network_bridge_arbiter #(
  parameter int unsigned AXIS_DATA_WIDTH  = 64,
  parameter int unsigned AXIS_KEEP_WIDTH  = 8,
  parameter int unsigned AXIS_TDEST_WIDTH = 16,
  parameter int unsigned AXIS_TUSER_WIDTH = 16,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  reliability_to_network_bridge_arbiter_if.slave  from_rel_outbound,
  reliability_to_network_bridge_arbiter_if.slave  from_rel_inbound,
  reliability_to_network_bridge_arbiter_if.master to_network_bridge,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt_outbound,
  output logic [CNT_WIDTH-1:0] o_pkt_cnt_inbound
);

  typedef enum logic [1:0] {StIdle, StLockOut, StLockIn} state_e;

  state_e state_q, state_d;
  // 0 = outbound granted last, 1 = inbound granted last
  logic   last_grant_q, last_grant_d;

  logic                        out_valid_q;
  logic [AXIS_DATA_WIDTH-1:0]  data_q, data_d;
  logic [AXIS_KEEP_WIDTH-1:0]  keep_q, keep_d;
  logic [AXIS_TDEST_WIDTH-1:0] id_q, id_d;
  logic [AXIS_TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [AXIS_TUSER_WIDTH-1:0] user_q, user_d;
  logic                        last_q, last_d;

  logic [CNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
  logic [CNT_WIDTH-1:0] cnt_in_q, cnt_in_d;

  logic can_load;
  logic grant_out, grant_in;
  logic acc_out, acc_in;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (acc_out) begin
          last_grant_d = 1'b0;
          if (!from_rel_outbound.tlast) state_d = StLockOut;
        end else if (acc_in) begin
          last_grant_d = 1'b1;
          if (!from_rel_inbound.tlast) state_d = StLockIn;
        end
      end
      StLockOut: if (acc_out && from_rel_outbound.tlast) state_d = StIdle;
      StLockIn:  if (acc_in && from_rel_inbound.tlast) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Grant selection and source treadys; a lock ignores the other source entirely.
  always_comb begin
    can_load  = !out_valid_q || to_network_bridge.tready;
    grant_out = 1'b0;
    grant_in  = 1'b0;
    case (state_q)
      StIdle: begin
        grant_in  = from_rel_inbound.tvalid && (!from_rel_outbound.tvalid || !last_grant_q);
        grant_out = from_rel_outbound.tvalid && !grant_in;
      end
      StLockOut: grant_out = 1'b1;
      StLockIn:  grant_in  = 1'b1;
      default: begin
        grant_out = 1'b0;
        grant_in  = 1'b0;
      end
    endcase
    from_rel_outbound.tready = grant_out && can_load && !i_rst;
    from_rel_inbound.tready  = grant_in && can_load && !i_rst;
    acc_out = from_rel_outbound.tvalid && from_rel_outbound.tready;
    acc_in  = from_rel_inbound.tvalid && from_rel_inbound.tready;
  end

  always_comb begin
    if (grant_in) begin
      data_d = from_rel_inbound.tdata;
      keep_d = from_rel_inbound.tkeep;
      id_d   = from_rel_inbound.tid;
      dest_d = from_rel_inbound.tdest;
      user_d = from_rel_inbound.tuser;
      last_d = from_rel_inbound.tlast;
    end else begin
      data_d = from_rel_outbound.tdata;
      keep_d = from_rel_outbound.tkeep;
      id_d   = from_rel_outbound.tid;
      dest_d = from_rel_outbound.tdest;
      user_d = from_rel_outbound.tuser;
      last_d = from_rel_outbound.tlast;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      id_q        <= '0;
      dest_q      <= '0;
      user_q      <= '0;
      last_q      <= 1'b0;
    end else if (acc_out || acc_in) begin
      out_valid_q <= 1'b1;
      data_q      <= data_d;
      keep_q      <= keep_d;
      id_q        <= id_d;
      dest_q      <= dest_d;
      user_q      <= user_d;
      last_q      <= last_d;
    end else if (to_network_bridge.tready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Counters saturate rather than wrap so a long debug run never reads back small.
  always_comb begin
    cnt_out_d = cnt_out_q;
    cnt_in_d  = cnt_in_q;
    if (acc_out && from_rel_outbound.tlast && (cnt_out_q != '1)) begin
      cnt_out_d = cnt_out_q + CNT_WIDTH'(1);
    end
    if (acc_in && from_rel_inbound.tlast && (cnt_in_q != '1)) begin
      cnt_in_d = cnt_in_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_out_q <= '0;
      cnt_in_q  <= '0;
    end else begin
      cnt_out_q <= cnt_out_d;
      cnt_in_q  <= cnt_in_d;
    end
  end

  assign to_network_bridge.tvalid = out_valid_q;
  assign to_network_bridge.tdata  = data_q;
  assign to_network_bridge.tkeep  = keep_q;
  assign to_network_bridge.tid    = id_q;
  assign to_network_bridge.tdest  = dest_q;
  assign to_network_bridge.tuser  = user_q;
  assign to_network_bridge.tlast  = last_q;

  assign o_pkt_cnt_outbound = cnt_out_q;
  assign o_pkt_cnt_inbound  = cnt_in_q;

endmodule

// File: tb/tb_reliability_to_network_bridge_arbiter.sv
// Directed bench for the reliability-to-network-bridge arbiter: reset, contention,
// in-packet bubbles, backpressure, counter saturation and reset mid-packet.
module tb_reliability_to_network_bridge_arbiter;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [15:0] id;
    logic [15:0] dest;
    logic [15:0] user;
    logic        last;
  } beat_t;

  typedef struct packed {
    beat_t b;
    logic  gap;
  } ent_t;

  logic clk;
  logic rst;
  logic [2:0] cnt_out, cnt_in;

  reliability_to_network_bridge_arbiter_if #(
    .DataWidth(64), .KeepWidth(8), .DestWidth(16), .UserWidth(16)
  ) ob_if ();
  reliability_to_network_bridge_arbiter_if #(
    .DataWidth(64), .KeepWidth(8), .DestWidth(16), .UserWidth(16)
  ) ib_if ();
  reliability_to_network_bridge_arbiter_if #(
    .DataWidth(64), .KeepWidth(8), .DestWidth(16), .UserWidth(16)
  ) nb_if ();

  reliability_to_network_bridge_arbiter #(
    .AXIS_DATA_WIDTH(64), .AXIS_KEEP_WIDTH(8), .AXIS_TDEST_WIDTH(16),
    .AXIS_TUSER_WIDTH(16), .CNT_WIDTH(3)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .from_rel_outbound  (ob_if),
    .from_rel_inbound   (ib_if),
    .to_network_bridge  (nb_if),
    .o_pkt_cnt_outbound (cnt_out),
    .o_pkt_cnt_inbound  (cnt_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;
  int    cyc    = 0;
  ent_t  q_out[$];
  ent_t  q_in[$];
  beat_t obs[$];
  int    obs_cyc[$];
  beat_t exp_q[$];
  bit    rdy_pat[$];
  bit    acc_o_last, acc_i_last;
  bit    prev_stall;
  beat_t stall_val;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    assert (got === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic beat_t mk(input int src, input int pkt, input int bt, input bit last);
    beat_t r;
    r.data = {16'hA5A5, 16'(src), 16'(pkt), 16'(bt)};
    r.keep = 8'(bt * 3 + pkt) ^ 8'h5A;
    r.id   = 16'(pkt * 7 + src);
    r.dest = ~r.id;
    r.user = 16'(bt) + 16'(src * 256);
    r.last = last;
    return r;
  endfunction

  // src 0 = outbound, 1 = inbound; gap_at inserts one idle cycle before that beat.
  task automatic push_pkt(input int src, input int pkt, input int n, input int gap_at);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.b   = mk(src, pkt, i, i == n - 1);
      e.gap = (i == gap_at);
      if (src == 0) q_out.push_back(e);
      else q_in.push_back(e);
    end
  endtask

  task automatic push_exp(input int src, input int pkt, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(src, pkt, i, i == n - 1));
  endtask

  task automatic present();
    ent_t e;
    if (q_out.size() > 0 && !q_out[0].gap) begin
      e = q_out[0];
      ob_if.tvalid = 1'b1;
      ob_if.tdata  = e.b.data;
      ob_if.tkeep  = e.b.keep;
      ob_if.tid    = e.b.id;
      ob_if.tdest  = e.b.dest;
      ob_if.tuser  = e.b.user;
      ob_if.tlast  = e.b.last;
    end else begin
      ob_if.tvalid = 1'b0;
    end
    if (q_in.size() > 0 && !q_in[0].gap) begin
      e = q_in[0];
      ib_if.tvalid = 1'b1;
      ib_if.tdata  = e.b.data;
      ib_if.tkeep  = e.b.keep;
      ib_if.tid    = e.b.id;
      ib_if.tdest  = e.b.dest;
      ib_if.tuser  = e.b.user;
      ib_if.tlast  = e.b.last;
    end else begin
      ib_if.tvalid = 1'b0;
    end
  endtask

  function automatic beat_t cur_out();
    beat_t r;
    r.data = nb_if.tdata;
    r.keep = nb_if.tkeep;
    r.id   = nb_if.tid;
    r.dest = nb_if.tdest;
    r.user = nb_if.tuser;
    r.last = nb_if.tlast;
    return r;
  endfunction

  // One clock: drive, settle, log handshakes, cross the edge, retire accepted beats.
  task automatic tick();
    ent_t  e;
    beat_t cur;
    present();
    nb_if.tready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
    #1;
    acc_o_last = ob_if.tvalid && ob_if.tready;
    acc_i_last = ib_if.tvalid && ib_if.tready;
    cur = cur_out();
    if (prev_stall) check("stall_stable", 128'(cur), 128'(stall_val));
    if (nb_if.tvalid && !nb_if.tready) begin
      check("stall_src_tready", 128'({ob_if.tready, ib_if.tready}), 128'(0));
      prev_stall = 1'b1;
      stall_val  = cur;
    end else begin
      prev_stall = 1'b0;
    end
    if (nb_if.tvalid && nb_if.tready) begin
      obs.push_back(cur);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc_o_last) void'(q_out.pop_front());
    else if (q_out.size() > 0 && q_out[0].gap) begin
      e = q_out.pop_front();
      e.gap = 1'b0;
      q_out.push_front(e);
    end
    if (acc_i_last) void'(q_in.pop_front());
    else if (q_in.size() > 0 && q_in[0].gap) begin
      e = q_in.pop_front();
      e.gap = 1'b0;
      q_in.push_front(e);
    end
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((q_out.size() > 0 || q_in.size() > 0 || nb_if.tvalid) && n < max) begin
      tick();
      n++;
    end
    check("drain_bound", 128'(n < max), 128'(1));
  endtask

  task automatic check_seq(input string tag);
    beat_t got;
    check({tag, "_len"}, 128'(obs.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs.size()) ? obs[i] : '0;
      check($sformatf("%s_beat%0d", tag, i), 128'(got), 128'(exp_q[i]));
    end
  endtask

  task automatic clear_logs();
    obs.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    q_out.delete();
    q_in.delete();
    rdy_pat.delete();
    present();
    nb_if.tready = 1'b1;
    prev_stall   = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    bit gapless;
    rst = 1'b1;
    ob_if.tvalid = 1'b0; ob_if.tdata = '0; ob_if.tkeep = '0; ob_if.tid = '0;
    ob_if.tdest  = '0;   ob_if.tuser = '0; ob_if.tlast = 1'b0;
    ib_if.tvalid = 1'b0; ib_if.tdata = '0; ib_if.tkeep = '0; ib_if.tid = '0;
    ib_if.tdest  = '0;   ib_if.tuser = '0; ib_if.tlast = 1'b0;
    nb_if.tready = 1'b1;
    prev_stall   = 1'b0;

    // Reset held 3 cycles with both sources offering a single-beat packet.
    push_pkt(0, 0, 1, -1);
    push_pkt(1, 0, 1, -1);
    present();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_src_tready", 128'({ob_if.tready, ib_if.tready}), 128'(0));
      check("rst_tvalid", 128'(nb_if.tvalid), 128'(0));
      check("rst_counters", 128'({cnt_out, cnt_in}), 128'(0));
    end
    check("rst_payload", 128'(cur_out()), 128'(0));
    rst = 1'b0;
    clear_logs();
    drain(20);
    push_exp(1, 0, 1);
    push_exp(0, 0, 1);
    check_seq("rst_first_tie");
    check("rst_cnt_out", 128'(cnt_out), 128'(1));
    check("rst_cnt_in", 128'(cnt_in), 128'(1));

    // Continuous contention with 3-beat packets: strict IN/OUT alternation, no bubbles.
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, k, 3, -1);
      push_pkt(1, k, 3, -1);
      push_exp(1, k, 3);
      push_exp(0, k, 3);
    end
    drain(60);
    check_seq("contend");
    gapless = 1'b1;
    for (int i = 1; i < obs_cyc.size(); i++) begin
      if (obs_cyc[i] != obs_cyc[i-1] + 1) gapless = 1'b0;
    end
    check("contend_no_bubble", 128'(gapless), 128'(1));
    check("contend_cnt_out", 128'(cnt_out), 128'(4));
    check("contend_cnt_in", 128'(cnt_in), 128'(4));

    // Outbound 4-beat packet with a bubble before its second beat keeps the lock.
    do_reset(1);
    push_pkt(0, 5, 4, 1);
    tick();
    check("bubble_out_first", 128'(acc_o_last), 128'(1));
    push_pkt(1, 6, 2, -1);
    drain(40);
    push_exp(0, 5, 4);
    push_exp(1, 6, 2);
    check_seq("bubble");

    // Backpressure 1,0,0,1,1,0 during an outbound 5-beat packet.
    do_reset(1);
    push_pkt(0, 9, 5, -1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    drain(40);
    push_exp(0, 9, 5);
    check_seq("bp");

    // Counter saturation at 7 with CNT_WIDTH=3.
    do_reset(1);
    for (int k = 0; k < 7; k++) push_pkt(0, k, 1, -1);
    drain(40);
    check("sat_cnt_at7", 128'(cnt_out), 128'(7));
    for (int k = 7; k < 9; k++) push_pkt(0, k, 1, -1);
    drain(40);
    check("sat_cnt_held", 128'(cnt_out), 128'(7));
    check("sat_cnt_in", 128'(cnt_in), 128'(0));
    check("sat_beats", 128'(obs.size()), 128'(9));

    // Reset after two beats of an inbound 4-beat packet.
    do_reset(1);
    push_pkt(1, 3, 4, -1);
    tick();
    tick();
    check("mid_pre_tvalid", 128'(nb_if.tvalid), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_tvalid_drop", 128'(nb_if.tvalid), 128'(0));
    check("mid_src_tready", 128'({ob_if.tready, ib_if.tready}), 128'(0));
    q_in.delete();
    present();
    rst = 1'b0;
    clear_logs();
    push_pkt(0, 4, 2, -1);
    tick();
    check("mid_rearb", 128'({acc_o_last, acc_i_last}), 128'(2'b10));
    drain(20);
    push_exp(0, 4, 2);
    check_seq("mid_after");
    check("mid_cnt_out", 128'(cnt_out), 128'(1));
    check("mid_cnt_in", 128'(cnt_in), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
